dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Three-way arbiter placing an instruction fetch port, a data
//               load port and a data store port onto one shared memory port.
//               Only one memory transaction is outstanding at a time.
//               Stores win over loads, and loads win over fetches. A streak
//               counter caps how many data grants in a row can pass over a
//               waiting fetch.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   STARVE_LIMIT       max consecutive data grants while a fetch waits
// Ports
//   clk                rising-edge clock
//   reset              asynchronous active-low reset
//   imem_ready         fetch request, held until imem_valid
//   imem_addr   [31:0] fetch address
//   imem_valid         one-cycle fetch completion pulse
//   imem_rdata  [31:0] registered fetch data
//   dmem_read_ready    load request, held until dmem_read_valid
//   dmem_read_address  load address
//   dmem_read_valid    one-cycle load completion pulse
//   dmem_read_data     registered load data
//   dmem_write_ready   store request, held until dmem_write_valid
//   dmem_write_address store address
//   dmem_write_data    store data
//   dmem_write_byte    store byte enables
//   dmem_write_valid   one-cycle store completion pulse
//   mem_req/mem_we     shared-memory request / write select
//   mem_addr/mem_wdata shared-memory address / write data
//   mem_wbyte          shared-memory byte enables
//   mem_ack            memory completion (any latency)
//   mem_rdata          memory read data, valid with mem_ack
// ============================================================================
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic        imem_valid,
  output logic [31:0] imem_rdata,
  // data load port
  input  logic        dmem_read_ready,
  input  logic [31:0] dmem_read_address,
  output logic        dmem_read_valid,
  output logic [31:0] dmem_read_data,
  // data store port
  input  logic        dmem_write_ready,
  input  logic [31:0] dmem_write_address,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_write_byte,
  output logic        dmem_write_valid,
  // shared memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wbyte,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int STREAK_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_INSTR = 2'd1;
  localparam logic [1:0] SRC_READ  = 2'd2;
  localparam logic [1:0] SRC_WRITE = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]          state;
  logic [1:0]          owner;     // requester holding the current transaction
  logic [STREAK_W-1:0] streak;    // data grants in a row while a fetch waited

  // --------------------------------------------------------------------------
  // Grant selection, only acted on in IDLE
  // --------------------------------------------------------------------------
  logic [1:0] grant_src;
  logic       grant_data;
  logic       starving;

  // A fetch that has already been passed over LIMIT times goes ahead of any
  // data request.
  assign starving = imem_ready && (streak == LIMIT);

  always_comb begin
    grant_src = SRC_NONE;
    if (starving) begin
      grant_src = SRC_INSTR;
    end else if (dmem_write_ready) begin
      grant_src = SRC_WRITE;
    end else if (dmem_read_ready) begin
      grant_src = SRC_READ;
    end else if (imem_ready) begin
      grant_src = SRC_INSTR;
    end
  end

  assign grant_data = (grant_src == SRC_WRITE) || (grant_src == SRC_READ);

  // Next streak value for a grant made this cycle. A data grant only counts
  // against the fetch port when a fetch is actually waiting.
  logic [STREAK_W-1:0] streak_next;

  always_comb begin
    streak_next = streak;
    if (grant_src == SRC_INSTR) begin
      streak_next = '0;
    end else if (grant_data) begin
      if (!imem_ready) begin
        streak_next = '0;
      end else if (streak != LIMIT) begin
        streak_next = streak + STREAK_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Main sequential block
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      owner            <= SRC_NONE;
      streak           <= '0;
      imem_valid       <= 1'b0;
      imem_rdata       <= '0;
      dmem_read_valid  <= 1'b0;
      dmem_read_data   <= '0;
      dmem_write_valid <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_wbyte        <= '0;
    end else begin
      // completion pulses last exactly one cycle
      imem_valid       <= 1'b0;
      dmem_read_valid  <= 1'b0;
      dmem_write_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_src != SRC_NONE) begin
            owner  <= grant_src;
            streak <= streak_next;
            case (grant_src)
              SRC_WRITE: begin
                if (dmem_write_byte == 4'h0) begin
                  // nothing to store: complete without touching memory
                  dmem_write_valid <= 1'b1;
                  state            <= ST_RESP;
                end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= dmem_write_address;
                  mem_wdata <= dmem_write_data;
                  mem_wbyte <= dmem_write_byte;
                  state     <= ST_BUSY;
                end
              end
              SRC_READ: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= dmem_read_address;
                mem_wdata <= '0;
                mem_wbyte <= 4'h0;
                state     <= ST_BUSY;
              end
              default: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= imem_addr;
                mem_wdata <= '0;
                mem_wbyte <= 4'h0;
                state     <= ST_BUSY;
              end
            endcase
          end
        end

        ST_BUSY: begin
          // request fields stay frozen until the memory acknowledges
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESP;
            case (owner)
              SRC_INSTR: begin
                imem_rdata <= mem_rdata;
                imem_valid <= 1'b1;
              end
              SRC_READ: begin
                dmem_read_data  <= mem_rdata;
                dmem_read_valid <= 1'b1;
              end
              default: begin
                // store: read data bus is don't-care
                dmem_write_valid <= 1'b1;
              end
            endcase
          end
        end

        ST_RESP: begin
          // the pulse is visible during this cycle; re-arbitrate from IDLE
          state <= ST_IDLE;
          owner <= SRC_NONE;
        end

        default: begin
          state <= ST_IDLE;
          owner <= SRC_NONE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed, table-driven bench for dmem_arbiter with a
//               requester model (drops a request after its valid pulse) and
//               a memory responder with programmable acknowledge delay.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_read_ready;
  logic [31:0] dmem_read_address;
  logic        dmem_read_valid;
  logic [31:0] dmem_read_data;
  logic        dmem_write_ready;
  logic [31:0] dmem_write_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_byte;
  logic        dmem_write_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbyte;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_ready         (imem_ready),
    .imem_addr          (imem_addr),
    .imem_valid         (imem_valid),
    .imem_rdata         (imem_rdata),
    .dmem_read_ready    (dmem_read_ready),
    .dmem_read_address  (dmem_read_address),
    .dmem_read_valid    (dmem_read_valid),
    .dmem_read_data     (dmem_read_data),
    .dmem_write_ready   (dmem_write_ready),
    .dmem_write_address (dmem_write_address),
    .dmem_write_data    (dmem_write_data),
    .dmem_write_byte    (dmem_write_byte),
    .dmem_write_valid   (dmem_write_valid),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wbyte          (mem_wbyte),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  int          cyc;
  int          rv_cnt, wv_cnt, iv_cnt;
  int          rv_cyc, wv_cyc, iv_cyc;
  int          glog[$];            // grant order: 0 fetch, 1 load, 2 store
  int          stable_err;
  logic        req_seen;
  logic        f_we;
  logic [31:0] f_addr, f_wdata;
  logic [3:0]  f_wbyte;
  logic        p_rv, p_wv, p_iv, p_req;
  logic [31:0] p_addr, p_wdata;
  logic        p_we;
  logic [3:0]  p_wbyte;
  logic        hold_reqs;
  logic        auto_ack;
  int          ack_delay;
  int          req_cycles;
  logic [31:0] resp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0;
    rv_cnt = 0; wv_cnt = 0; iv_cnt = 0;
    rv_cyc = -1; wv_cyc = -1; iv_cyc = -1;
    glog.delete();
    stable_err = 0;
    req_seen = 1'b0;
    f_we = 1'b0; f_addr = '0; f_wdata = '0; f_wbyte = '0;
    p_rv = 1'b0; p_wv = 1'b0; p_iv = 1'b0; p_req = 1'b0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0; p_wbyte = '0;
    req_cycles = 0;
  endtask

  task automatic drop_all();
    imem_ready = 1'b0;
    dmem_read_ready = 1'b0;
    dmem_write_ready = 1'b0;
  endtask

  // One clock: requester model, observation, memory responder.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!hold_reqs) begin
      if (p_rv) dmem_read_ready = 1'b0;
      if (p_wv) dmem_write_ready = 1'b0;
      if (p_iv) imem_ready = 1'b0;
    end
    if (dmem_read_valid)  begin rv_cnt++; rv_cyc = cyc; end
    if (dmem_write_valid) begin wv_cnt++; wv_cyc = cyc; end
    if (imem_valid)       begin iv_cnt++; iv_cyc = cyc; end
    if (mem_req && !p_req) begin
      glog.push_back(mem_we ? 2 : ((mem_addr == imem_addr) ? 0 : 1));
      if (!req_seen) begin
        f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata; f_wbyte = mem_wbyte;
      end
      req_seen = 1'b1;
    end
    if (mem_req && p_req &&
        (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we || mem_wbyte !== p_wbyte))
      stable_err++;
    if (auto_ack && mem_req) begin
      mem_ack   = (req_cycles == ack_delay);
      mem_rdata = resp_data;
      req_cycles++;
    end else begin
      if (auto_ack) mem_ack = 1'b0;
      req_cycles = 0;
    end
    p_rv = dmem_read_valid; p_wv = dmem_write_valid; p_iv = imem_valid;
    p_req = mem_req; p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we; p_wbyte = mem_wbyte;
  endtask

  // --------------------------------------------------------------------------
  // Single-requester vectors, applied from IDLE in order (data registers
  // carry over from one vector to the next)
  // --------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic        ir;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbyte;
    int          delay;
    logic [31:0] rdata;
    logic        exp_req;
    logic        exp_we;
    logic [3:0]  exp_wbyte;
    int          exp_lat;
    logic [31:0] exp_imem;
    logic [31:0] exp_dread;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hDEADBEEF,
                1'b1, 1'b0, 4'h0, 3, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'hF, 1, 32'hBAD0BAD0,
                1'b1, 1'b1, 4'hF, 3, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 0, 32'h00000013,
                1'b1, 1'b0, 4'h0, 2, 32'h00000013, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h99999999, 4'h0, 1, 32'h77777777,
                1'b0, 1'b0, 4'h0, 1, 32'h00000013, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 5, 32'hCAFEF00D,
                1'b1, 1'b0, 4'h0, 7, 32'h00000013, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h404, 32'h0, 4'h0, 2, 32'h12345678,
                1'b1, 1'b0, 4'h0, 4, 32'h12345678, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h208, 32'hA5A5A5A5, 4'h3, 0, 32'h0BADF00D,
                1'b1, 1'b1, 4'h3, 2, 32'h12345678, 32'hCAFEF00D};
  end

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    drop_all();
    imem_addr = 32'h0; dmem_read_address = 32'h0;
    dmem_write_address = 32'h0; dmem_write_data = 32'h0; dmem_write_byte = 4'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    hold_reqs = 1'b0; auto_ack = 1'b1; ack_delay = 1; resp_data = 32'h0;
    clear_obs();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_valids", {29'b0, imem_valid, dmem_read_valid, dmem_write_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_dread", dmem_read_data, 32'h0);
    chk("rst_imem", imem_rdata, 32'h0);
    reset = 1'b1;
    step();
    step();

    // table vectors
    for (int v = 0; v < NV; v++) begin
      clear_obs();
      ack_delay = vecs[v].delay;
      resp_data = vecs[v].rdata;
      if (vecs[v].wr) begin
        dmem_write_address = vecs[v].addr;
        dmem_write_data    = vecs[v].wdata;
        dmem_write_byte    = vecs[v].wbyte;
        dmem_write_ready   = 1'b1;
      end
      if (vecs[v].rd) begin
        dmem_read_address = vecs[v].addr;
        dmem_read_ready   = 1'b1;
      end
      if (vecs[v].ir) begin
        imem_addr  = vecs[v].addr;
        imem_ready = 1'b1;
      end
      repeat (12) step();

      chk($sformatf("v%0d_req_issued", v), {31'b0, req_seen}, {31'b0, vecs[v].exp_req});
      if (vecs[v].exp_req) begin
        chk($sformatf("v%0d_mem_addr", v), f_addr, vecs[v].addr);
        chk($sformatf("v%0d_mem_we", v), {31'b0, f_we}, {31'b0, vecs[v].exp_we});
        chk($sformatf("v%0d_mem_wbyte", v), {28'b0, f_wbyte}, {28'b0, vecs[v].exp_wbyte});
        if (vecs[v].wr)
          chk($sformatf("v%0d_mem_wdata", v), f_wdata, vecs[v].wdata);
      end
      if (vecs[v].wr) begin
        chk($sformatf("v%0d_wv_count", v), wv_cnt, 1);
        chk($sformatf("v%0d_wv_cycle", v), wv_cyc, vecs[v].exp_lat);
        chk($sformatf("v%0d_other_valids", v), rv_cnt + iv_cnt, 0);
      end else if (vecs[v].rd) begin
        chk($sformatf("v%0d_rv_count", v), rv_cnt, 1);
        chk($sformatf("v%0d_rv_cycle", v), rv_cyc, vecs[v].exp_lat);
        chk($sformatf("v%0d_other_valids", v), wv_cnt + iv_cnt, 0);
      end else begin
        chk($sformatf("v%0d_iv_count", v), iv_cnt, 1);
        chk($sformatf("v%0d_iv_cycle", v), iv_cyc, vecs[v].exp_lat);
        chk($sformatf("v%0d_other_valids", v), wv_cnt + rv_cnt, 0);
      end
      chk($sformatf("v%0d_imem_rdata", v), imem_rdata, vecs[v].exp_imem);
      chk($sformatf("v%0d_dmem_read_data", v), dmem_read_data, vecs[v].exp_dread);
      chk($sformatf("v%0d_stable", v), stable_err, 0);
      chk($sformatf("v%0d_no_req_after", v), {31'b0, mem_req}, 32'h0);
    end

    // simultaneous store and load to the same address: store first
    clear_obs();
    ack_delay = 1; resp_data = 32'h55AA55AA;
    dmem_write_address = 32'h200; dmem_write_data = 32'h11223344; dmem_write_byte = 4'hF;
    dmem_read_address  = 32'h200;
    dmem_write_ready = 1'b1; dmem_read_ready = 1'b1;
    repeat (15) step();
    chk("simul_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("simul_first_is_write", glog[0], 2);
      chk("simul_second_is_read", glog[1], 1);
    end
    chk("simul_wv_count", wv_cnt, 1);
    chk("simul_rv_count", rv_cnt, 1);
    chk("simul_wv_cycle", wv_cyc, 3);
    chk("simul_rv_cycle", rv_cyc, 7);
    chk("simul_dread", dmem_read_data, 32'h55AA55AA);

    // starvation: store and fetch requests held continuously
    clear_obs();
    hold_reqs = 1'b1; ack_delay = 1; resp_data = 32'h0000_00AA;
    imem_addr = 32'h800;
    dmem_write_address = 32'h600; dmem_write_data = 32'h0F0F0F0F; dmem_write_byte = 4'hF;
    dmem_write_ready = 1'b1; imem_ready = 1'b1;
    while (glog.size() < 10 && cyc < 200) step();
    chk("starve_grant_count", glog.size(), 10);
    if (glog.size() >= 10) begin
      for (int g = 0; g < 10; g++)
        chk($sformatf("starve_grant%0d", g), glog[g], (g % 5 == 4) ? 0 : 2);
    end
    hold_reqs = 1'b0;
    drop_all();
    repeat (10) step();
    chk("starve_idle_after", {31'b0, mem_req}, 32'h0);
    chk("starve_imem", imem_rdata, 32'h0000_00AA);

    // stray acknowledges while idle
    clear_obs();
    auto_ack = 1'b0;
    mem_rdata = 32'hFFFF0000;
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    repeat (3) step();
    chk("stray_valids", rv_cnt + wv_cnt + iv_cnt, 0);
    chk("stray_no_req", {31'b0, req_seen}, 32'h0);
    chk("stray_dread_held", dmem_read_data, 32'h55AA55AA);

    // reset while BUSY, then a late acknowledge
    clear_obs();
    dmem_read_address = 32'h100;
    dmem_read_ready = 1'b1;
    step();
    step();
    chk("busy_before_reset", {31'b0, mem_req}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_dread", dmem_read_data, 32'h0);
    chk("rstmid_imem", imem_rdata, 32'h0);
    dmem_read_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
    mem_rdata = 32'h13579BDF;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (4) step();
    chk("late_ack_valids", rv_cnt + wv_cnt + iv_cnt, 0);
    chk("late_ack_no_req", {31'b0, req_seen}, 32'h0);
    chk("late_ack_dread", dmem_read_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
